// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus bundle for the dcache_ctrl data cache controller.
`timescale 1ns/1ps
interface dcache_ctrl_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  // Controller view.
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Pipeline plus off-chip memory view.
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = 5;
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e              r_state;
  logic [TAG_W-1:0]    r_tag   [NUM_LINES];
  logic [LINE_W-1:0]   r_data  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [2:0]          w_sel;
  logic [LINE_W-1:0]   w_line;
  logic                w_idle;
  logic                w_hit;
  logic                w_unused_addr;

  assign w_idx         = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign w_tag         = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_sel         = bus.cpu_addr_i[4:2];
  assign w_line        = r_data[w_idx];
  assign w_idle        = (r_state == S_IDLE);
  assign w_hit         = bus.cpu_req_i && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_addr = ^bus.cpu_addr_i[1:0];

  // Hits answer in the same cycle; a miss stalls before any state has moved.
  assign bus.cpu_rdata_o = (w_idle && w_hit) ? w_line[{w_sel, 5'b0} +: 32] : 32'h0;
  assign bus.cpu_stall_o = !w_idle || (bus.cpu_req_i && !w_hit);
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit && bus.cpu_we_i) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (bus.cpu_req_i && !w_hit) begin
            r_mem_req <= 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, 5'b0};
              r_mem_wdata <= w_line;
              r_state     <= S_WRITEBACK;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, 5'b0};
              r_state    <= S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          // Request stays high across the chain into the fetch phase.
          if (bus.mem_ack_i) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, 5'b0};
            r_state    <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (bus.mem_ack_i) begin
            r_mem_req      <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits
  // already mark their contents as meaningless after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_idle && w_hit && bus.cpu_we_i)
        r_data[w_idx][{w_sel, 5'b0} +: 32] <= bus.cpu_wdata_i;
      if ((r_state == S_ALLOCATE) && bus.mem_ack_i) begin
        r_data[w_idx] <= bus.mem_rdata_i;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        r_refill;

  // The first hit after a refill is the replayed miss, not a new hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_refill   <= 1'b0;
    end else begin
      if (w_idle && w_hit) begin
        if (r_refill) r_refill  <= 1'b0;
        else          r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_idle && bus.cpu_req_i && !w_hit)
        r_miss_cnt <= r_miss_cnt + 32'd1;
      if ((r_state == S_ALLOCATE) && bus.mem_ack_i)
        r_refill <= 1'b1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`else
  // Statistics counters are not built.
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a hand-driven memory responder.
`timescale 1ns/1ps
module tb_dcache_ctrl;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dcache_ctrl_if #(.LINE_W(LINE_W), .ADDR_W(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dcache_ctrl #(.NUM_LINES(32), .LINE_W(LINE_W), .ADDR_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base,
                                                  input logic [31:0] step);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + step * i;
    return l;
  endfunction

  task automatic cpu_drive(input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.cpu_req_i   = req;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    #1;
  endtask

  // Waits (bounded) for a request, checks it, holds it for 'delay' cycles, then acks.
  task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [LINE_W-1:0] exp_wdata, input int delay,
                       input logic [LINE_W-1:0] line);
    for (int i = 0; i < 20 && !bus.mem_req_o; i++) begin
      @(negedge clk); #1;
    end
    check({tag, "_req"},  bus.mem_req_o,  1'b1);
    check({tag, "_we"},   bus.mem_we_o,   exp_we);
    check({tag, "_addr"}, bus.mem_addr_o, exp_addr);
    if (exp_we) check({tag, "_wdata"}, bus.mem_wdata_o, exp_wdata);
    repeat (delay - 1) begin
      @(negedge clk); #1;
    end
    check({tag, "_hold_req"},  bus.mem_req_o,  1'b1);
    check({tag, "_hold_addr"}, bus.mem_addr_o, exp_addr);
    check({tag, "_stall"},     bus.cpu_stall_o, 1'b1);
    @(negedge clk);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = line;
    @(negedge clk);
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    #1;
  endtask

  logic [LINE_W-1:0] line_a, line_b, line_c, line_d, line_e, exp_line;

  initial begin
    line_a = make_line(32'h1111_1111, 32'h1111_1111);
    line_b = make_line(32'hB000_0000, 32'h1);
    line_c = make_line(32'hC000_0000, 32'h1);
    line_d = make_line(32'hD000_0000, 32'h1);
    line_e = make_line(32'hE000_0000, 32'h1);

    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req",   bus.mem_req_o,   1'b0);
    check("rst_we",    bus.mem_we_o,    1'b0);
    check("rst_addr",  bus.mem_addr_o,  32'h0);
    check("rst_wdata", bus.mem_wdata_o, '0);
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    check("rst_rdata", bus.cpu_rdata_o, 32'h0);

    // Cold load miss, fetch only.
    cpu_drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check("ld40_miss_stall", bus.cpu_stall_o, 1'b1);
    serve("fill40", 1'b0, 32'h0000_0040, '0, 3, line_a);
    check("ld40_data",  bus.cpu_rdata_o, 32'h1111_1111);
    check("ld40_stall", bus.cpu_stall_o, 1'b0);
    check("ld40_req",   bus.mem_req_o,   1'b0);

    // Hit on the same line, different word.
    cpu_drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    check("ld44_data",  bus.cpu_rdata_o, 32'h2222_2222);
    check("ld44_stall", bus.cpu_stall_o, 1'b0);
    check("ld44_req",   bus.mem_req_o,   1'b0);

    // Store hit dirties the line; conflicting load forces write-back then fetch.
    cpu_drive(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    check("st40_stall", bus.cpu_stall_o, 1'b0);
    cpu_drive(1'b1, 1'b0, 32'h0000_0440, 32'h0);
    check("ld440_stall", bus.cpu_stall_o, 1'b1);
    exp_line = line_a;
    exp_line[31:0] = 32'hDEAD_BEEF;
    serve("wb40", 1'b1, 32'h0000_0040, exp_line, 2, '0);
    serve("fill440", 1'b0, 32'h0000_0440, '0, 2, line_b);
    check("ld440_data",  bus.cpu_rdata_o, 32'hB000_0000);
    check("ld440_stall", bus.cpu_stall_o, 1'b0);
`ifdef DCACHE_STATS_EN
    check("stats_hit",  hit_cnt,  32'd2);
    check("stats_miss", miss_cnt, 32'd2);
`endif

    // Store miss to a clean line: fetch only, then merge.
    cpu_drive(1'b1, 1'b1, 32'h0000_0880, 32'h1234_5678);
    check("st880_stall", bus.cpu_stall_o, 1'b1);
    serve("fill880", 1'b0, 32'h0000_0880, '0, 1, line_c);
    check("st880_done_stall", bus.cpu_stall_o, 1'b0);
    cpu_drive(1'b1, 1'b0, 32'h0000_0880, 32'h0);
    check("ld880_data", bus.cpu_rdata_o, 32'h1234_5678);
    check("ld880_req",  bus.mem_req_o,   1'b0);
    cpu_drive(1'b1, 1'b0, 32'h0000_0884, 32'h0);
    check("ld884_data", bus.cpu_rdata_o, 32'hC000_0001);

    // Conflicting miss on the now-dirty line writes it back.
    cpu_drive(1'b1, 1'b0, 32'h0000_1080, 32'h0);
    exp_line = line_c;
    exp_line[31:0] = 32'h1234_5678;
    serve("wb880", 1'b1, 32'h0000_0880, exp_line, 2, '0);
    serve("fill1080", 1'b0, 32'h0000_1080, '0, 2, line_d);
    check("ld1080_data", bus.cpu_rdata_o, 32'hD000_0000);
    cpu_drive(1'b1, 1'b0, 32'h0000_109C, 32'h0);
    check("ld109c_data", bus.cpu_rdata_o, 32'hD000_0007);

    // Reset during the fetch phase aborts the transfer.
    cpu_drive(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    for (int i = 0; i < 20 && !bus.mem_req_o; i++) begin
      @(negedge clk); #1;
    end
    check("abort_req_before", bus.mem_req_o,  1'b1);
    check("abort_addr",       bus.mem_addr_o, 32'h0000_2000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_req_after",   bus.mem_req_o,   1'b0);
    check("abort_remiss_stall", bus.cpu_stall_o, 1'b1);
    serve("refill2000", 1'b0, 32'h0000_2000, '0, 2, line_e);
    check("ld2000_data", bus.cpu_rdata_o, 32'hE000_0000);

    // Reset also cleared the line at 0x1080: clean miss, no write-back.
    cpu_drive(1'b1, 1'b0, 32'h0000_1084, 32'h0);
    check("ld1084_remiss", bus.cpu_stall_o, 1'b1);
    serve("refill1080", 1'b0, 32'h0000_1080, '0, 1, line_d);
    check("ld1084_data", bus.cpu_rdata_o, 32'hD000_0001);

    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("idle_stall", bus.cpu_stall_o, 1'b0);
    check("idle_rdata", bus.cpu_rdata_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
